// File: rtl/mem_pkg.sv
// Shared types for the block mover: FSM state encoding and mode constants.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mover_state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_block_mover_if.sv
// Single-port data-memory bus: one address pointer, combinational read,
// write on posedge when MemWriteEn is high.
interface mem_block_mover_if #(
  parameter int W = 8,
  parameter int A = 8
);
  logic [A-1:0] MemAddress;
  logic         MemWriteEn;
  logic [W-1:0] MemDataOut;
  logic [W-1:0] MemDataIn;

  modport master (output MemAddress, output MemWriteEn, output MemDataOut, input  MemDataIn);
  modport slave  (input  MemAddress, input  MemWriteEn, input  MemDataOut, output MemDataIn);
endinterface

// File: rtl/mem_block_mover.sv
// Block copy / fill engine sitting beside the core on the data-memory bus.
// Copy alternates READ/WRITE (2 cycles per byte), fill stays in WRITE
// (1 cycle per byte). Addresses wrap mod 2**A; copy is strictly ascending.
module mem_block_mover
  import mem_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Start,
  input  logic               Mode,
  input  logic [A-1:0]       SrcAddr,
  input  logic [A-1:0]       DstAddr,
  input  logic [A:0]         Length,
  input  logic [W-1:0]       FillValue,
  input  logic               Abort,
  mem_block_mover_if.master  mem,
  output logic               Busy,
  output logic               Done,
  output logic [A:0]         Count
);

  mover_state_t state_q, state_d;
  logic [A-1:0] src_q, src_d;
  logic [A-1:0] dst_q, dst_d;
  logic [A:0]   len_q, len_d;
  logic [A:0]   cnt_q, cnt_d;
  logic [W-1:0] fill_q, fill_d;
  logic [W-1:0] hold_q, hold_d;
  logic         mode_q, mode_d;
  logic [A:0]   cnt_inc;

  assign cnt_inc = cnt_q + {{A{1'b0}}, 1'b1};

  // State and operand registers; reset abandons any operation in flight.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      hold_q  <= '0;
      mode_q  <= MODE_COPY;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state and datapath update; Abort in READ/WRITE drops to IDLE
  // without advancing pointers so Count reflects bytes actually written.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    hold_d  = hold_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          src_d  = SrcAddr;
          dst_d  = DstAddr;
          len_d  = Length;
          fill_d = FillValue;
          mode_d = Mode;
          cnt_d  = '0;
          if (Length == '0)           state_d = DONE;
          else if (Mode == MODE_COPY) state_d = READ;
          else                        state_d = WRITE;
        end
      end
      READ: begin
        if (Abort) begin
          state_d = IDLE;
        end else begin
          hold_d  = mem.MemDataIn;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (Abort) begin
          state_d = IDLE;
        end else begin
          src_d = src_q + {{(A-1){1'b0}}, 1'b1};
          dst_d = dst_q + {{(A-1){1'b0}}, 1'b1};
          cnt_d = cnt_inc;
          if (cnt_inc == len_q)        state_d = DONE;
          else if (mode_q == MODE_COPY) state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from state; Abort gates the write combinationally.
  always_comb begin
    mem.MemAddress = '0;
    mem.MemWriteEn = 1'b0;
    mem.MemDataOut = '0;
    case (state_q)
      READ:  mem.MemAddress = src_q;
      WRITE: begin
        mem.MemAddress = dst_q;
        mem.MemWriteEn = !Abort;
        mem.MemDataOut = (mode_q == MODE_FILL) ? fill_q : hold_q;
      end
      default: ;
    endcase
  end

  assign Busy  = (state_q == READ) || (state_q == WRITE);
  assign Done  = (state_q == DONE);
  assign Count = cnt_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover with a behavioural 256x8 memory responder.
module tb_mem_block_mover;

  logic       Clk = 1'b0;
  logic       ResetN;
  logic       Start, Mode, Abort;
  logic [7:0] SrcAddr, DstAddr, FillValue;
  logic [8:0] Length;
  logic       Busy, Done;
  logic [8:0] Count;

  int nt = 0;
  int nf = 0;

  mem_block_mover_if #(.W(8), .A(8)) bus ();

  mem_block_mover #(.W(8), .A(8)) dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .Mode(Mode),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Length(Length),
    .FillValue(FillValue), .Abort(Abort), .mem(bus),
    .Busy(Busy), .Done(Done), .Count(Count)
  );

  always #5 Clk = ~Clk;

  // Memory responder plus a bench-side preload port and a write counter.
  logic [7:0] mem [256];
  logic       pre_we = 1'b0;
  logic [7:0] pre_addr = '0, pre_data = '0;
  int         wr_cnt = 0;

  assign bus.MemDataIn = mem[bus.MemAddress];

  always @(posedge Clk) begin
    if (bus.MemWriteEn) begin
      mem[bus.MemAddress] <= bus.MemDataOut;
      wr_cnt <= wr_cnt + 1;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge Clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge Clk);
    pre_we = 1'b0;
  endtask

  task automatic pulse_start(input logic m, input logic [7:0] s, input logic [7:0] d,
                             input logic [8:0] l, input logic [7:0] f);
    @(negedge Clk);
    Start = 1'b1; Mode = m; SrcAddr = s; DstAddr = d; Length = l; FillValue = f;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // Runs one operation to completion; returns busy cycles, done pulses,
  // cycle index of Done (relative to first cycle after Start), writes, timeout.
  task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d,
                        input logic [8:0] l, input logic [7:0] f,
                        output int busy, output int dones, output int done_at,
                        output int wrs, output bit tmo);
    int w0;
    busy = 0; dones = 0; done_at = -1; tmo = 1'b1;
    w0 = wr_cnt;
    pulse_start(m, s, d, l, f);
    for (int i = 0; i < 600; i++) begin
      if (!Busy && !Done) begin tmo = 1'b0; break; end
      if (Busy) busy++;
      if (Done) begin dones++; done_at = i; end
      @(negedge Clk);
    end
    wrs = wr_cnt - w0;
  endtask

  task automatic test_reset;
    ResetN = 1'b0; Start = 0; Mode = 0; Abort = 0;
    SrcAddr = 0; DstAddr = 0; Length = 0; FillValue = 0;
    #12;
    nt++; if (bus.MemWriteEn !== 1'b0) begin nf++; $display("FAIL reset_we got %b want 0", bus.MemWriteEn); end
    nt++; if ({Busy, Done} !== 2'b00) begin nf++; $display("FAIL reset_busy_done got %b want 00", {Busy, Done}); end
    nt++; if (Count !== 9'd0 || bus.MemAddress !== 8'd0 || bus.MemDataOut !== 8'd0) begin
      nf++; $display("FAIL reset_regs cnt=%0d addr=%0h dout=%0h want 0", Count, bus.MemAddress, bus.MemDataOut); end
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_copy;
    int busy, dones, dat, wrs; bit tmo;
    logic [7:0] src [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 4; i++) poke(8'h10 + 8'(i), src[i]);
    run_op(1'b0, 8'h10, 8'h40, 9'd4, 8'h00, busy, dones, dat, wrs, tmo);
    nt++; if (tmo) begin nf++; $display("FAIL copy_timeout got timeout want completion"); end
    nt++; if (busy != 8 || dones != 1 || dat != 8) begin
      nf++; $display("FAIL copy_timing busy=%0d dones=%0d done_at=%0d want 8 1 8", busy, dones, dat); end
    nt++; if (Count !== 9'd4 || wrs != 4) begin nf++; $display("FAIL copy_count cnt=%0d wrs=%0d want 4 4", Count, wrs); end
    for (int i = 0; i < 4; i++) begin
      nt++; if (mem[8'h40 + 8'(i)] !== src[i] || mem[8'h10 + 8'(i)] !== src[i]) begin
        nf++; $display("FAIL copy_data[%0d] dst=%0h src=%0h want %0h", i, mem[8'h40 + 8'(i)], mem[8'h10 + 8'(i)], src[i]); end
    end
  endtask

  task automatic test_fill_wrap;
    int busy, dones, dat, wrs; bit tmo;
    poke(8'h01, 8'h33);
    run_op(1'b1, 8'h00, 8'hFE, 9'd3, 8'h5A, busy, dones, dat, wrs, tmo);
    nt++; if (tmo || busy != 3 || dones != 1 || dat != 3) begin
      nf++; $display("FAIL fill_timing tmo=%0b busy=%0d dones=%0d done_at=%0d want 0 3 1 3", tmo, busy, dones, dat); end
    nt++; if (mem[8'hFE] !== 8'h5A || mem[8'hFF] !== 8'h5A || mem[8'h00] !== 8'h5A) begin
      nf++; $display("FAIL fill_data got %0h %0h %0h want 5a 5a 5a", mem[8'hFE], mem[8'hFF], mem[8'h00]); end
    nt++; if (mem[8'h01] !== 8'h33 || Count !== 9'd3) begin
      nf++; $display("FAIL fill_bound mem01=%0h cnt=%0d want 33 3", mem[8'h01], Count); end
  endtask

  task automatic test_zero_length;
    int busy, dones, dat, wrs; bit tmo;
    run_op(1'b1, 8'h00, 8'h70, 9'd0, 8'hEE, busy, dones, dat, wrs, tmo);
    nt++; if (tmo || wrs != 0 || busy != 0) begin nf++; $display("FAIL zero_writes tmo=%0b wrs=%0d busy=%0d want 0 0 0", tmo, wrs, busy); end
    nt++; if (dones != 1 || dat != 0 || Count !== 9'd0) begin
      nf++; $display("FAIL zero_done dones=%0d done_at=%0d cnt=%0d want 1 0 0", dones, dat, Count); end
  endtask

  task automatic test_abort;
    int w0;
    for (int i = 0; i < 2; i++) poke(8'h60 + 8'(i), 8'h00);
    poke(8'h50, 8'h11); poke(8'h51, 8'h22);
    w0 = wr_cnt;
    pulse_start(1'b0, 8'h50, 8'h60, 9'd8, 8'h00);
    // cycles: 0 READ, 1 WRITE, 2 READ, 3 WRITE (aborted)
    repeat (3) @(negedge Clk);
    Abort = 1'b1;
    #1;
    nt++; if (bus.MemWriteEn !== 1'b0 || Busy !== 1'b1) begin
      nf++; $display("FAIL abort_gate we=%b busy=%b want 0 1", bus.MemWriteEn, Busy); end
    @(negedge Clk);
    Abort = 1'b0;
    nt++; if (Busy !== 1'b0 || Done !== 1'b0 || Count !== 9'd1) begin
      nf++; $display("FAIL abort_state busy=%b done=%b cnt=%0d want 0 0 1", Busy, Done, Count); end
    @(negedge Clk);
    nt++; if (wr_cnt - w0 != 1 || mem[8'h60] !== 8'h11 || mem[8'h61] !== 8'h00 || Done !== 1'b0) begin
      nf++; $display("FAIL abort_mem wrs=%0d m60=%0h m61=%0h done=%b want 1 11 00 0", wr_cnt - w0, mem[8'h60], mem[8'h61], Done); end
  endtask

  task automatic test_overlap_ignored_start;
    int dones = 0, dat = -1;
    bit tmo = 1'b1;
    poke(8'h20, 8'd1); poke(8'h21, 8'd2); poke(8'h22, 8'd3); poke(8'h23, 8'd9);
    poke(8'h80, 8'h00);
    pulse_start(1'b0, 8'h20, 8'h21, 9'd3, 8'h00);
    for (int i = 0; i < 50; i++) begin
      if (!Busy && !Done) begin tmo = 1'b0; break; end
      if (Done) begin dones++; dat = i; end
      if (i == 2) begin
        Start = 1'b1; Mode = 1'b1; DstAddr = 8'h80; Length = 9'd5; FillValue = 8'hEE;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
    end
    Start = 1'b0;
    nt++; if (mem[8'h21] !== 8'd1 || mem[8'h22] !== 8'd1 || mem[8'h23] !== 8'd1) begin
      nf++; $display("FAIL overlap_data got %0d %0d %0d want 1 1 1", mem[8'h21], mem[8'h22], mem[8'h23]); end
    nt++; if (tmo || dones != 1 || dat != 6 || Count !== 9'd3 || mem[8'h80] !== 8'h00) begin
      nf++; $display("FAIL ignored_start tmo=%0b dones=%0d done_at=%0d cnt=%0d m80=%0h want 0 1 6 3 00",
                     tmo, dones, dat, Count, mem[8'h80]); end
  endtask

  task automatic test_async_reset;
    int w0;
    poke(8'h92, 8'h11); poke(8'h99, 8'h11);
    w0 = wr_cnt;
    pulse_start(1'b1, 8'h00, 8'h90, 9'd10, 8'h77);
    repeat (2) @(negedge Clk);
    #2 ResetN = 1'b0;
    #1;
    nt++; if (bus.MemWriteEn !== 1'b0 || Busy !== 1'b0 || Count !== 9'd0) begin
      nf++; $display("FAIL areset_imm we=%b busy=%b cnt=%0d want 0 0 0", bus.MemWriteEn, Busy, Count); end
    repeat (2) @(negedge Clk);
    ResetN = 1'b1;
    repeat (2) @(negedge Clk);
    nt++; if (wr_cnt - w0 != 2 || mem[8'h92] !== 8'h11 || mem[8'h99] !== 8'h11) begin
      nf++; $display("FAIL areset_writes wrs=%0d m92=%0h m99=%0h want 2 11 11", wr_cnt - w0, mem[8'h92], mem[8'h99]); end
    nt++; if (Busy !== 1'b0 || Done !== 1'b0 || bus.MemAddress !== 8'd0) begin
      nf++; $display("FAIL areset_idle busy=%b done=%b addr=%0h want 0 0 0", Busy, Done, bus.MemAddress); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill_wrap();
    test_zero_length();
    test_abort();
    test_overlap_ignored_start();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end

endmodule
